// File: rtl/huffman_decoder.sv
// huffman_decoder: serial receive end of the huffman_top encoder stream.
// The stream is one bit per cycle, MSB first. It starts with NSYM 4-bit
// code-length fields and continues with the canonical payload codewords.
// The block emits one 4-bit symbol for each decoded codeword.
//
// Ports:
//   clk, rst_n   rising-edge clock; asynchronous active-low reset
//   in_data      serial bit, valid every cycle from in_start to in_done
//   in_start     one-cycle pulse on header bit 0 (aborts any stream in flight)
//   in_done      one-cycle pulse on the last payload bit
//   sym_out      decoded symbol, qualified by sym_valid
//   sym_valid    one-cycle strobe, registered, the cycle after the last code bit
//   dec_done     one-cycle end-of-stream pulse, the cycle after in_done
//   err          sticky stream error; cleared by in_start or reset
//   dbg_state    current FSM state (IDLE=0, HDR=1, PAY=2, DRAIN=3)
//
// Handshake: there is no valid/ready pair. Input bits are contiguous and are
// never back-pressured. Each output strobe is valid for exactly one cycle.
//
// Optional feature: define HUFF_DEC_ERR_EN to compile in stream-error
// checking. That covers in_done in the header, a truncated final codeword,
// and an over-length codeword, which drains bits until in_done. Without it,
// err is constant 0 and an over-length codeword is silently dropped.
module huffman_decoder #(
  parameter int NSYM   = 9,
  parameter int MAXLEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_data,
  input  logic       in_start,
  input  logic       in_done,
  output logic [3:0] sym_out,
  output logic       sym_valid,
  output logic       dec_done,
  output logic       err,
  output logic [1:0] dbg_state
);

`ifdef HUFF_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int HBITS = NSYM * 4;
  localparam int HCW   = $clog2(HBITS + 1);
  localparam int CW    = MAXLEN + 1;          // code arithmetic width
  localparam int LW    = $clog2(MAXLEN + 1);  // codeword length counter width

  typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [HCW-1:0]    hcnt_q, hcnt_d;
  logic [2:0]        field_q, field_d;
  logic [MAXLEN-1:0] code_q, code_d;
  logic [LW-1:0]     len_q, len_d;
  logic [3:0]        sym_out_q, sym_out_d;
  logic              sym_valid_q, sym_valid_d;
  logic              dec_done_q, dec_done_d;
  logic              err_q, err_d;
  logic [3:0]        len_tab_q [NSYM];
  logic [3:0]        len_tab_d [NSYM];
  logic [CW-1:0]     count_q [1:MAXLEN];
  logic [CW-1:0]     count_d [1:MAXLEN];

  // Decode datapath
  logic [CW-1:0] first_c [1:MAXLEN];
  logic [3:0]    new_field;
  logic [CW-1:0] code_n;
  logic [LW-1:0] len_n;
  logic [CW-1:0] first_sel, count_sel, diff, rank;
  logic          match;
  logic [3:0]    sym_c;

  assign new_field = {field_q, in_data};
  assign code_n    = {code_q, in_data};
  assign len_n     = len_q + 1'b1;

  // Canonical first-code per length. This is rebuilt combinationally from
  // the length histogram, so the first payload bit can follow the header
  // with no table-build gap.
  always_comb begin
    first_c[1] = '0;
    for (int l = 2; l <= MAXLEN; l++) begin
      first_c[l] = (first_c[l-1] + count_q[l-1]) << 1;
    end
  end

  // Candidate match at the length the code reaches with this bit. The offset
  // into the length class selects the symbol: the diff-th symbol, in
  // ascending index, whose length equals len_n.
  always_comb begin
    first_sel = '0;
    count_sel = '0;
    for (int l = 1; l <= MAXLEN; l++) begin
      if (len_n == LW'(l)) begin
        first_sel = first_c[l];
        count_sel = count_q[l];
      end
    end
    diff  = code_n - first_sel;
    match = (len_n != '0) && (diff < count_sel);
    rank  = '0;
    sym_c = '0;
    for (int s = 0; s < NSYM; s++) begin
      if (len_tab_q[s] == 4'(len_n)) begin
        if (rank == diff) sym_c = 4'(s);
        rank = rank + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    field_d     = field_q;
    code_d      = code_q;
    len_d       = len_q;
    sym_out_d   = sym_out_q;
    sym_valid_d = 1'b0;
    dec_done_d  = 1'b0;
    err_d       = err_q;
    len_tab_d   = len_tab_q;
    count_d     = count_q;
    if (in_start) begin
      // A new stream from any state; the current bit is header bit 0.
      state_d = HDR;
      hcnt_d  = HCW'(1);
      field_d = {2'b00, in_data};
      code_d  = '0;
      len_d   = '0;
      err_d   = 1'b0;
      for (int s = 0; s < NSYM; s++) len_tab_d[s] = '0;
      for (int l = 1; l <= MAXLEN; l++) count_d[l] = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        HDR: begin
          hcnt_d  = hcnt_q + 1'b1;
          field_d = {field_q[1:0], in_data};
          if (hcnt_q[1:0] == 2'b11) begin
            for (int s = 0; s < NSYM; s++) begin
              if (int'(hcnt_q[HCW-1:2]) == s) len_tab_d[s] = new_field;
            end
            for (int l = 1; l <= MAXLEN; l++) begin
              if (new_field == 4'(l)) count_d[l] = count_q[l] + 1'b1;
            end
          end
          if (hcnt_q == HCW'(HBITS - 1)) begin
            state_d = PAY;
            hcnt_d  = '0;
          end
          if (in_done) begin
            dec_done_d = 1'b1;
            state_d    = IDLE;
            hcnt_d     = '0;
            if (ERR_EN) err_d = 1'b1;
          end
        end
        PAY: begin
          if (match) begin
            sym_valid_d = 1'b1;
            sym_out_d   = sym_c;
            code_d      = '0;
            len_d       = '0;
          end else if (len_n == LW'(MAXLEN)) begin
            code_d = '0;
            len_d  = '0;
            if (ERR_EN) begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else begin
            code_d = code_n[MAXLEN-1:0];
            len_d  = len_n;
          end
          if (in_done) begin
            // The final bit is decoded above; a miss leaves a partial codeword.
            dec_done_d = 1'b1;
            state_d    = IDLE;
            code_d     = '0;
            len_d      = '0;
            if (ERR_EN && !match) err_d = 1'b1;
          end
        end
        DRAIN: begin
          if (in_done) begin
            dec_done_d = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      field_q     <= '0;
      code_q      <= '0;
      len_q       <= '0;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      dec_done_q  <= 1'b0;
      err_q       <= 1'b0;
      for (int s = 0; s < NSYM; s++) len_tab_q[s] <= '0;
      for (int l = 1; l <= MAXLEN; l++) count_q[l] <= '0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      field_q     <= field_d;
      code_q      <= code_d;
      len_q       <= len_d;
      sym_out_q   <= sym_out_d;
      sym_valid_q <= sym_valid_d;
      dec_done_q  <= dec_done_d;
      err_q       <= err_d;
      len_tab_q   <= len_tab_d;
      count_q     <= count_d;
    end
  end

  assign sym_out   = sym_out_q;
  assign sym_valid = sym_valid_q;
  assign dec_done  = dec_done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Testbench for huffman_decoder. Directed streams are driven through a small
// stream model that builds canonical codes by enumeration and matches bit
// strings against them. Every driven cycle queues the outputs expected right
// after that clock edge. A single compare process checks each queued entry.
module tb_huffman_decoder;
  localparam int NSYM   = 9;
  localparam int MAXLEN = 8;
`ifdef HUFF_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_data, in_start, in_done;
  logic [3:0] sym_out;
  logic       sym_valid, dec_done, err;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  huffman_decoder #(.NSYM(NSYM), .MAXLEN(MAXLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_start (in_start),
    .in_done  (in_done),
    .sym_out  (sym_out),
    .sym_valid(sym_valid),
    .dec_done (dec_done),
    .err      (err),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Expected entry layout: {sym_valid, sym_out[3:0], dec_done, err}
  logic [6:0] exp_q[$];
  logic [3:0] got_q[$];
  logic [6:0] cmp_e;
  logic       model_err;

  int dec_lens[NSYM]    = '{2, 3, 3, 3, 3, 4, 4, 4, 4};
  int single_lens[NSYM] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
  int one0_lens[NSYM]   = '{1, 0, 0, 0, 0, 0, 0, 0, 0};

  // Scoreboard compare
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      checks++;
      if (sym_valid !== cmp_e[6] || dec_done !== cmp_e[1] || err !== cmp_e[0] ||
          (cmp_e[6] && sym_out !== cmp_e[5:2])) begin
        errors++;
        $display("FAIL cycle_out @%0t: got valid=%b sym=%0d done=%b err=%b, want valid=%b sym=%0d done=%b err=%b",
                 $time, sym_valid, sym_out, dec_done, err, cmp_e[6], cmp_e[5:2], cmp_e[1], cmp_e[0]);
      end
      if (sym_valid === 1'b1) got_q.push_back(sym_out);
    end
  end

  // Driver tasks
  task automatic drive(input logic r, input logic b, input logic st, input logic dn,
                       input logic [6:0] e);
    @(negedge clk);
    rst_n    = r;
    in_data  = b;
    in_start = st;
    in_done  = dn;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, {1'b0, 4'd0, 1'b0, model_err});
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    model_err = 1'b0;
  endtask

  // Canonical code of a symbol: enumerate symbols by (length, index).
  function automatic int canon_code(input int lens[NSYM], input int sym);
    int code = 0;
    for (int l = 1; l <= MAXLEN; l++) begin
      for (int k = 0; k < NSYM; k++) begin
        if (lens[k] == l) begin
          if (k == sym) return code;
          code++;
        end
      end
      code = code << 1;
    end
    return -1;
  endfunction

  task automatic send_header(input int lens[NSYM], input int nbits);
    int n = 0;
    model_err = 1'b0;
    for (int k = 0; k < NSYM; k++)
      for (int b = 3; b >= 0; b--) begin
        if (n < nbits) drive(1'b1, lens[k][b], (n == 0), 1'b0, 7'd0);
        n++;
      end
  endtask

  // Full stream: header, then npay payload bits (MSB of pay[npay-1:0] first).
  // Without with_done the stream is left open for an abort by the next start.
  task automatic run_stream(input int lens[NSYM], input logic [31:0] pay, input int npay,
                            input bit with_done);
    int   acc = 0;
    int   alen = 0;
    bit   drain = 0;
    bit   v, last;
    int   s;
    logic b;
    send_header(lens, NSYM * 4);
    for (int i = 0; i < npay; i++) begin
      b    = pay[npay-1-i];
      last = with_done && (i == npay - 1);
      v    = 0;
      s    = 0;
      if (!drain) begin
        acc = acc * 2 + int'(b);
        alen++;
        for (int k = 0; k < NSYM; k++)
          if (lens[k] == alen && canon_code(lens, k) == acc) begin
            v = 1;
            s = k;
          end
        if (v) begin
          acc  = 0;
          alen = 0;
        end else if (alen == MAXLEN) begin
          acc  = 0;
          alen = 0;
          if (ERR_EN) begin
            model_err = 1'b1;
            drain     = 1;
          end
        end
      end
      if (last && ERR_EN && !v) model_err = 1'b1;
      drive(1'b1, b, 1'b0, last, {v, 4'(s), last, model_err});
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic settle();
    idle(2);
    @(posedge clk);
    #2;
  endtask

  task automatic check_got(input string name, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int ex[4];
    bit ok;
    int g0;
    ex = '{e0, e1, e2, e3};
    ok = (got_q.size() == n);
    for (int i = 0; i < n && ok; i++) if (int'(got_q[i]) != ex[i]) ok = 0;
    g0 = (got_q.size() > 0) ? int'(got_q[0]) : -1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d symbols (first %0d), want %0d symbols (first %0d)",
               name, got_q.size(), g0, n, e0);
    end
    got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_data = 1'b0; in_start = 1'b0; in_done = 1'b0; model_err = 1'b0;

    // Model pins: canonical codes hand-derived from the test plan.
    check_int("code_sym0", canon_code(dec_lens, 0), 0);   // 00
    check_int("code_sym1", canon_code(dec_lens, 1), 2);   // 010
    check_int("code_sym4", canon_code(dec_lens, 4), 5);   // 101
    check_int("code_sym8", canon_code(dec_lens, 8), 15);  // 1111
    check_int("code_single", canon_code(single_lens, 5), 0);

    // Reset state
    reset_cycles(3);
    #2;
    check_int("reset_state", int'(dbg_state), 0);
    idle(3);

    // Decode: 00 010 1111 -> 0, 1, 8; dec_done with the symbol-8 strobe.
    run_stream(dec_lens, 32'b000101111, 9, 1);
    settle();
    check_got("decode_syms", 3, 0, 1, 8, 0);

    // Single symbol: code "0" -> symbol 5, three in a row.
    run_stream(single_lens, 32'b000, 3, 1);
    settle();
    check_got("single_syms", 3, 5, 5, 5, 0);

    // Truncation: 01 then in_done.
    run_stream(dec_lens, 32'b01, 2, 1);
    settle();
    check_got("trunc_syms", 0, 0, 0, 0, 0);
    check_int("trunc_err", int'(err), ERR_EN ? 1 : 0);

    // Over-length: eight 1s, then in_done on a ninth bit.
    run_stream(one0_lens, 32'h1ff, 9, 1);
    settle();
    check_got("overlen_syms", 0, 0, 0, 0, 0);
    check_int("overlen_err", int'(err), ERR_EN ? 1 : 0);

    // Abort A: over-length stream left open, then a fresh decode stream.
    run_stream(one0_lens, 32'h3ff, 10, 0);
    run_stream(dec_lens, 32'b000101111, 9, 1);
    settle();
    check_got("abort_a_syms", 3, 0, 1, 8, 0);
    check_int("abort_a_err", int'(err), 0);

    // Abort B: 010 then a partial 1, restart into the single-symbol stream.
    run_stream(dec_lens, 32'b0101, 4, 0);
    run_stream(single_lens, 32'b000, 3, 1);
    settle();
    check_got("abort_b_syms", 4, 1, 5, 5, 5);

    // Reset mid-header, then a full stream.
    send_header(dec_lens, 10);
    reset_cycles(2);
    idle(1);
    run_stream(dec_lens, 32'b000101111, 9, 1);
    settle();
    check_got("post_reset_syms", 3, 0, 1, 8, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Serial Huffman decoder, the receive end of the `huffman_top` encoder stream. It consumes a one-bit-per-cycle, MSB-first bitstream framed by start and done pulses. The stream carries a canonical code-length header followed by the payload codewords. The block emits one 4-bit symbol per decoded codeword and signals end of stream.

## Interface
Parameters:
- `NSYM`, default 9: number of symbols in the alphabet (symbols 0..NSYM-1).
- `MAXLEN`, default 8: maximum codeword length in bits. Each header length field is 4 bits.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_data` in 1: serial stream bit, MSB first. It is valid every cycle from `in_start` through `in_done`, inclusive.
- `in_start` in 1: one-cycle pulse, coincident with the first header bit.
- `in_done` in 1: one-cycle pulse, coincident with the last payload bit.
- `sym_out` out 4: decoded symbol.
- `sym_valid` out 1: one-cycle strobe; `sym_out` is valid while it is high.
- `dec_done` out 1: one-cycle pulse marking end of stream.
- `err` out 1: sticky stream-error flag. It clears on `in_start` or reset.

## Operation
- States: IDLE, HDR, PAY, DRAIN.
- IDLE:
  - `in_start` → HDR; the current `in_data` is taken as header bit 0.
  - All other input is ignored.
- HDR:
  - Shifts in NSYM×4 bits; field k is the code length of symbol k, with 0 meaning unused.
  - A length-counter array `count[1..MAXLEN]` is updated as each field completes.
  - After the last header bit → PAY.
- Canonical code construction (combinational, from `count`):
  - `first[1]=0`; `first[L]=(first[L-1]+count[L-1])<<1`.
  - Codes are assigned in order of (length, symbol index).
- PAY decode loop:
  - Each cycle, `code={code,in_data}` and `len=len+1`.
  - Match when `code-first[len] < count[len]` (unsigned, MAXLEN+1 bits).
  - On a match, `sym_out` is the (code-first[len])-th symbol, in ascending index, whose length equals `len`. This is found by a combinational scan over the NSYM length fields.
  - After a match, `code` and `len` clear.
- End of stream in PAY: when `in_done` arrives, the final bit is decoded normally, `dec_done` pulses, and the FSM → IDLE.
- Header with at most one nonzero length equal to 1: the code "0" decodes to that symbol.
- `in_start` in any non-IDLE state: aborts the current stream, clears `err`, restarts HDR. The current bit becomes header bit 0.
- Reset mid-operation: returns to IDLE and clears all tables; no `dec_done` is emitted.

## Timing
- Reset values: `sym_out`=0, `sym_valid`=0, `dec_done`=0, `err`=0. State = IDLE; `count`, `code`, `len` = 0.
- Header takes NSYM×4 cycles, and there is no table-build gap. The first payload bit is accepted in the cycle after the last header bit.
- `sym_valid`/`sym_out` are registered. They assert the cycle after the final bit of the codeword is sampled.
- `dec_done` asserts the cycle after `in_done` is sampled. It is coincident with the final `sym_valid` when the last bit completes a codeword.
- Maximum throughput is one symbol per cycle, for 1-bit codes.
- Input bits are contiguous. The block has no back-pressure and no input gaps.

## Configuration
- `HUFF_DEC_ERR_EN` defined: error checking is compiled in. Each of the following sets `err`:
  - `in_done` during HDR.
  - `in_done` arriving with a partial codeword (`len` nonzero after the final bit).
  - `len` reaching MAXLEN with no match; the FSM then → DRAIN, discarding bits until `in_done`, then pulses `dec_done`.
- `HUFF_DEC_ERR_EN` undefined:
  - `err` is tied to 0.
  - An over-length codeword silently clears `code`/`len` and decoding continues.
  - `in_done` in any state still pulses `dec_done` and returns to IDLE.

## Test plan
- Decode:
  - Stimulus: header lengths sym0..8 = 2,3,3,3,3,4,4,4,4; payload bits 00 010 1111.
  - Canonical codes: 0=00, 1=010, 2=011, 3=100, 4=101, 5=1100, 6=1101, 7=1110, 8=1111.
  - Response: symbols 0, 1, 8. `dec_done` pulses one cycle after `in_done`, together with the symbol 8 strobe. `err`=0.
- Single symbol:
  - Stimulus: header with only sym5 having length 1; payload 0 0 0.
  - Response: three consecutive `sym_valid` strobes, each with `sym_out`=5.
- Truncation (EN): same header as the first scenario; payload 01 with `in_done` on the second bit → `err`=1, `dec_done` pulses, no symbol emitted.
- Abort:
  - Stimulus: `in_start` re-asserted mid-payload, followed by a fresh stream.
  - Response: `err` clears; only the new stream's symbols are emitted.
- Reset: `rst_n` low mid-HDR → all outputs 0, no `dec_done`; a subsequent full stream decodes correctly.
- Over-length (EN):
  - Stimulus: header containing only sym0 with length 1; payload 1×8 then `in_done`.
  - Response: `err`=1 after 8 bits; no symbols; `dec_done` one cycle after `in_done`.
